// File: rtl/tlb_cache_if.sv
// Bundle of request/response and MMU walk signals for tlb_cache.
// slave: the TLB side. master: the requester/MMU side driving it.
interface tlb_cache_if #(
  parameter int VPN_W = 20
) ();
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_vaddr;
  logic             resp_valid;
  logic [31:0]      resp_paddr;
  logic             resp_fault;
  logic             walk_req;
  logic [VPN_W-1:0] walk_vpn;
  logic             walk_ack;
  logic [31:0]      walk_pte;
  logic             flush;

  modport slave (
    input  req_valid, req_vaddr, walk_ack, walk_pte, flush,
    output req_ready, resp_valid, resp_paddr, resp_fault, walk_req, walk_vpn
  );

  modport master (
    output req_valid, req_vaddr, walk_ack, walk_pte, flush,
    input  req_ready, resp_valid, resp_paddr, resp_fault, walk_req, walk_vpn
  );
endinterface

// File: rtl/tlb_cache.sv
// Fully associative TLB in front of the page-table MMU.
// Lookup compares the request VPN against every valid entry in parallel; a miss
// issues one walk and refills the round-robin victim from a valid PTE.
// Optional feature macro: TLB_STATS_EN adds saturating hit/miss counters.
module tlb_cache #(
  parameter int ENTRIES = 8,
  parameter int VPN_W   = 20,
  parameter int PPN_W   = 20
) (
  input  logic        clk,
  input  logic        reset,
  tlb_cache_if.slave  bus
`ifdef TLB_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WALK, S_RESP} state_t;

  state_t           r_state, w_state_next;
  logic [31:0]      r_vaddr, w_vaddr_next;
  logic             r_resp_valid, w_resp_valid_next;
  logic [31:0]      r_resp_paddr, w_resp_paddr_next;
  logic             r_resp_fault, w_resp_fault_next;
  logic             r_walk_req, w_walk_req_next;
  logic [VPN_W-1:0] r_walk_vpn, w_walk_vpn_next;
  logic [PTR_W-1:0] r_rr_ptr;

  logic [ENTRIES-1:0] r_valid;
  logic [VPN_W-1:0]   r_vpn [ENTRIES];
  logic [PPN_W-1:0]   r_ppn [ENTRIES];

  logic [ENTRIES-1:0] w_match;
  logic [ENTRIES-1:0] w_we;
  logic               w_hit;
  logic [PPN_W-1:0]   w_hit_ppn;
  logic [VPN_W-1:0]   w_vpn;
  logic [PPN_W-1:0]   w_pte_ppn;
  logic               w_fill;
  logic               w_hit_evt;
  logic               w_miss_evt;
  logic               w_unused_pte_bits;

  assign w_vpn             = r_vaddr[12 +: VPN_W];
  assign w_pte_ppn         = bus.walk_pte[12 +: PPN_W];
  assign w_unused_pte_bits = ^bus.walk_pte[11:1];

  // Per-entry comparators and refill write enables.
  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      assign w_match[gi] = r_valid[gi] && (r_vpn[gi] == w_vpn);
      assign w_we[gi]    = w_fill && (r_rr_ptr == PTR_W'(gi));
    end
  endgenerate

  // Flush in the lookup cycle makes the lookup see an empty TLB.
  assign w_hit = (|w_match) && !bus.flush;

  // Priority select: an (illegal) multi-hit resolves to the lowest index.
  always_comb begin
    w_hit_ppn = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_match[i]) w_hit_ppn = r_ppn[i];
    end
  end

  // Next-state and next-output logic for the request FSM.
  always_comb begin
    w_state_next      = r_state;
    w_vaddr_next      = r_vaddr;
    w_resp_valid_next = 1'b0;
    w_resp_paddr_next = r_resp_paddr;
    w_resp_fault_next = r_resp_fault;
    w_walk_req_next   = r_walk_req;
    w_walk_vpn_next   = r_walk_vpn;
    w_fill            = 1'b0;
    w_hit_evt         = 1'b0;
    w_miss_evt        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_vaddr_next = bus.req_vaddr;
          w_state_next = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (w_hit) begin
          w_hit_evt         = 1'b1;
          w_resp_valid_next = 1'b1;
          w_resp_paddr_next = 32'({w_hit_ppn, r_vaddr[11:0]});
          w_resp_fault_next = 1'b0;
          w_state_next      = S_RESP;
        end else begin
          w_miss_evt      = 1'b1;
          w_walk_req_next = 1'b1;
          w_walk_vpn_next = w_vpn;
          w_state_next    = S_WALK;
        end
      end
      S_WALK: begin
        if (bus.walk_ack) begin
          w_walk_req_next   = 1'b0;
          w_resp_valid_next = 1'b1;
          w_state_next      = S_RESP;
          if (bus.walk_pte[0]) begin
            w_resp_paddr_next = 32'({w_pte_ppn, r_vaddr[11:0]});
            w_resp_fault_next = 1'b0;
            // A coincident flush wins over the refill.
            w_fill            = !bus.flush;
          end else begin
            w_resp_paddr_next = '0;
            w_resp_fault_next = 1'b1;
          end
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // FSM state, response/walk output registers and the replacement pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_vaddr      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_paddr <= '0;
      r_resp_fault <= 1'b0;
      r_walk_req   <= 1'b0;
      r_walk_vpn   <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_vaddr      <= w_vaddr_next;
      r_resp_valid <= w_resp_valid_next;
      r_resp_paddr <= w_resp_paddr_next;
      r_resp_fault <= w_resp_fault_next;
      r_walk_req   <= w_walk_req_next;
      r_walk_vpn   <= w_walk_vpn_next;
      if (w_fill) r_rr_ptr <= r_rr_ptr + PTR_W'(1);
    end
  end

  // Entry valid bits: flush clears everything, refill sets the victim.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else if (bus.flush) begin
      r_valid <= '0;
    end else begin
      r_valid <= r_valid | w_we;
    end
  end

  // Entry tag/data storage; only the valid bits need a reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (w_we[i]) begin
        r_vpn[i] <= w_vpn;
        r_ppn[i] <= w_pte_ppn;
      end
    end
  end

`ifdef TLB_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Saturating lookup outcome counters, untouched by flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit_evt && (r_hit_cnt != 32'hFFFF_FFFF))   r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss_evt && (r_miss_cnt != 32'hFFFF_FFFF)) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

  assign bus.req_ready  = (r_state == S_IDLE) && !reset;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_paddr = r_resp_paddr;
  assign bus.resp_fault = r_resp_fault;
  assign bus.walk_req   = r_walk_req;
  assign bus.walk_vpn   = r_walk_vpn;

endmodule

// File: tb/tb_tlb_cache.sv
// Self-checking bench for tlb_cache: directed vector table, hand-written reset
// and flush sequences, then randomized traffic against a slot/fill-count model.
module tb_tlb_cache;

  logic clk;
  logic reset;

  tlb_cache_if #(.VPN_W(20)) bus ();

`ifdef TLB_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  tlb_cache #(.ENTRIES(8), .VPN_W(20), .PPN_W(20)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus)
`ifdef TLB_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;

  // Reference model: slot k holds the fill whose sequence number is k mod 8.
  bit          m_valid [8];
  logic [19:0] m_vpn   [8];
  logic [19:0] m_ppn   [8];
  int          m_fills;

  typedef struct {
    logic [31:0] va;
    logic [31:0] pte;
    int          dly;
    bit          fl_ack;
    bit          exp_hit;
    logic [31:0] exp_paddr;
    bit          exp_fault;
  } vec_t;

  vec_t tab[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic void m_flush();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endfunction

  function automatic void m_clear();
    m_flush();
    m_fills = 0;
  endfunction

  function automatic bit m_lookup(input logic [19:0] vpn, output logic [19:0] ppn);
    ppn = '0;
    for (int i = 0; i < 8; i++) begin
      if (m_valid[i] && m_vpn[i] == vpn) begin
        ppn = m_ppn[i];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic void m_fill(input logic [19:0] vpn, input logic [19:0] ppn);
    int s;
    s = m_fills % 8;
    m_valid[s] = 1'b1;
    m_vpn[s]   = vpn;
    m_ppn[s]   = ppn;
    m_fills++;
  endfunction

  function automatic vec_t mk(input logic [31:0] va, input logic [31:0] pte, input int dly,
                              input bit fl, input bit h, input logic [31:0] pa, input bit f);
    vec_t v;
    v.va = va; v.pte = pte; v.dly = dly; v.fl_ack = fl;
    v.exp_hit = h; v.exp_paddr = pa; v.exp_fault = f;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"},      32'(bus.req_ready),  32'd0);
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_resp_paddr"}, bus.resp_paddr,      32'd0);
    chk({tag, "_resp_fault"}, 32'(bus.resp_fault), 32'd0);
    chk({tag, "_walk_req"},   32'(bus.walk_req),   32'd0);
    chk({tag, "_walk_vpn"},   32'(bus.walk_vpn),   32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_release_ready", 32'(bus.req_ready), 32'd1);
    m_clear();
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    m_flush();
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  // One request end to end; flush options: fl_lk in LOOKUP, fl_wk on the first
  // walk cycle (no ack), fl_ack together with walk_ack.
  task automatic txn(input logic [31:0] va, input logic [31:0] pte, input int dly,
                     input bit fl_ack, input bit fl_lk, input bit fl_wk,
                     input bit use_tab, input bit t_hit, input logic [31:0] t_paddr, input bit t_fault);
    logic [19:0] vpn, mppn, first_vpn;
    bit          mh, e_hit, e_fault, ok, got, prev_wr, vpn_bad, wr_at_resp;
    logic [31:0] e_paddr, r_pa;
    bit          r_f;
    int          k, wcyc, walks, lat, e_lat;

    vpn = va[31:12];
    if (fl_lk) m_flush();
    mh = m_lookup(vpn, mppn);
    if (use_tab) begin
      e_hit = t_hit; e_paddr = t_paddr; e_fault = t_fault;
    end else begin
      e_hit   = mh;
      e_fault = !mh && !pte[0];
      e_paddr = mh ? {mppn, va[11:0]} : (pte[0] ? {pte[31:12], va[11:0]} : 32'd0);
    end
    e_lat = e_hit ? 2 : 3 + dly;

    wait_ready(ok);
    bus.req_valid = 1'b1;
    bus.req_vaddr = va;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;

    k = 0; wcyc = 0; walks = 0; got = 1'b0; prev_wr = 1'b0; vpn_bad = 1'b0;
    lat = 0; r_pa = '0; r_f = 1'b0; first_vpn = '0; wr_at_resp = 1'b0;
    while (!got && k < 60) begin
      @(negedge clk);
      k++;
      bus.walk_ack = 1'b0;
      bus.flush    = 1'b0;
      if (bus.resp_valid) begin
        got = 1'b1; lat = k; r_pa = bus.resp_paddr; r_f = bus.resp_fault;
        wr_at_resp = bus.walk_req;
      end else begin
        if (k == 1 && fl_lk) bus.flush = 1'b1;
        if (bus.walk_req) begin
          if (!prev_wr) begin
            walks++;
            if (walks == 1) first_vpn = bus.walk_vpn;
          end
          if (bus.walk_vpn !== first_vpn) vpn_bad = 1'b1;
          wcyc++;
          if (fl_wk && wcyc == 1) bus.flush = 1'b1;
          if (wcyc == dly + 1) begin
            bus.walk_ack = 1'b1;
            bus.walk_pte = pte;
            if (fl_ack) bus.flush = 1'b1;
          end
        end
      end
      prev_wr = bus.walk_req;
    end
    bus.walk_ack = 1'b0;
    bus.flush    = 1'b0;

    chk("resp_seen",    32'(got),   32'd1);
    chk("resp_latency", 32'(lat),   32'(e_lat));
    chk("resp_paddr",   r_pa,       e_paddr);
    chk("resp_fault",   32'(r_f),   32'(e_fault));
    chk("walk_count",   32'(walks), e_hit ? 32'd0 : 32'd1);
    if (walks > 0) begin
      chk("walk_vpn",        32'(first_vpn), 32'(vpn));
      chk("walk_vpn_stable", 32'(vpn_bad),   32'd0);
      chk("walk_req_drop",   32'(wr_at_resp), 32'd0);
    end
    @(negedge clk);
    chk("resp_pulse", 32'(bus.resp_valid), 32'd0);
    chk("ready_idle", 32'(bus.req_ready),  32'd1);

    $display("txn %0d va=%h pte=%h dly=%0d hit=%0d paddr=%h fault=%0d lat=%0d walks=%0d",
             txn_no, va, pte, dly, e_hit, r_pa, r_f, lat, walks);
    txn_no++;

    if (!mh) begin
      if (fl_wk) m_flush();
      if (fl_ack) m_flush();
      else if (pte[0]) m_fill(vpn, pte[31:12]);
    end
  endtask

  task automatic run_tab(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      txn(tab[i].va, tab[i].pte, tab[i].dly, tab[i].fl_ack, 1'b0, 1'b0,
          1'b1, tab[i].exp_hit, tab[i].exp_paddr, tab[i].exp_fault);
    end
  endtask

  initial begin
    int n_a, n_b;
    bit ok;
    logic [19:0] rv;

    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_vaddr = '0; bus.walk_ack = 1'b0;
    bus.walk_pte = '0; bus.flush = 1'b0;
    m_clear();

    // Cold miss, hit, fault, fault retry.
    tab.push_back(mk(32'h0000_3ABC, 32'h0004_5001, 3, 0, 0, 32'h0004_5ABC, 0));
    tab.push_back(mk(32'h0000_3FFF, 32'h0000_0000, 0, 0, 1, 32'h0004_5FFF, 0));
    tab.push_back(mk(32'h0001_0000, 32'h0000_0000, 1, 0, 0, 32'h0000_0000, 1));
    tab.push_back(mk(32'h0001_0000, 32'h0000_0000, 2, 0, 0, 32'h0000_0000, 1));
    n_a = tab.size();
    // Replacement after reset: VPN 0..8 fill, VPN 1..8 hit, VPN0 evicted,
    // its refill lands in slot 1 and evicts VPN1.
    for (int v = 0; v <= 8; v++)
      tab.push_back(mk({12'h0, 8'(v), 12'(v * 16)}, {12'h0, 8'(v) + 8'h00, 12'h001} | 32'h0010_0000,
                       v % 3, 0, 0, {12'h0, 8'(v), 12'(v * 16)} | 32'h0010_0000, 0));
    for (int v = 1; v <= 8; v++)
      tab.push_back(mk({12'h0, 8'(v), 12'(v * 16)}, 32'h0, 0, 0, 1,
                       {12'h0, 8'(v), 12'(v * 16)} | 32'h0010_0000, 0));
    tab.push_back(mk(32'h0000_0000, 32'h0020_0001, 1, 0, 0, 32'h0020_0000, 0));
    tab.push_back(mk(32'h0000_1010, 32'h0020_1001, 0, 0, 0, 32'h0020_1010, 0));
    n_b = tab.size();
    // After a standalone flush; then flush coincident with walk_ack.
    tab.push_back(mk(32'h0000_5123, 32'h0030_5001, 1, 0, 0, 32'h0030_5123, 0));
    tab.push_back(mk(32'h0007_7123, 32'h0037_7001, 2, 1, 0, 32'h0037_7123, 0));
    tab.push_back(mk(32'h0007_7123, 32'h0037_8001, 0, 0, 0, 32'h0037_8123, 0));
    tab.push_back(mk(32'h0000_5123, 32'h0030_6001, 1, 0, 0, 32'h0030_6123, 0));

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("por_release_ready", 32'(bus.req_ready), 32'd1);

    run_tab(0, 2);
`ifdef TLB_STATS_EN
    chk("stats_hit",  hit_cnt,  32'd1);
    chk("stats_miss", miss_cnt, 32'd1);
`endif
    run_tab(2, n_a);

    do_reset();
    run_tab(n_a, n_b);
    pulse_flush();
    run_tab(n_b, tab.size());

    // Randomized traffic over a small VPN pool so hits and evictions occur.
    for (int i = 0; i < 150; i++) begin
      int d;
      rv = 20'($urandom_range(0, 11));
      d  = $urandom_range(0, 4);
      txn({rv, 12'($urandom)},
          {20'($urandom), 11'($urandom), 1'($urandom_range(0, 9) != 0)},
          d, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
          (d > 0) && ($urandom_range(0, 19) == 0), 1'b0, 1'b0, 32'd0, 1'b0);
      if ($urandom_range(0, 29) == 0) pulse_flush();
    end

    // Reset while a walk is outstanding, then a stale ack in IDLE.
    wait_ready(ok);
    bus.req_valid = 1'b1;
    bus.req_vaddr = 32'h00AB_C000;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = bus.walk_req;
    end
    chk("midwalk_walk_req_seen", 32'(ok), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midwalk");
    @(negedge clk);
    reset = 1'b0;
    bus.walk_ack = 1'b1;
    bus.walk_pte = 32'h0099_9001;
    @(negedge clk);
    bus.walk_ack = 1'b0;
    chk("stale_ack_resp",  32'(bus.resp_valid), 32'd0);
    chk("stale_ack_walk",  32'(bus.walk_req),   32'd0);
    chk("stale_ack_ready", 32'(bus.req_ready),  32'd1);
    m_clear();
    txn(32'h00AB_C444, 32'h00DE_F001, 1, 0, 0, 0, 1'b0, 1'b0, 32'd0, 1'b0);
    txn(32'h0000_5000, 32'h0012_3001, 0, 0, 0, 0, 1'b0, 1'b0, 32'd0, 1'b0);
    txn(32'h00AB_C888, 32'h0, 0, 0, 0, 0, 1'b0, 1'b0, 32'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
